// File: rtl/tank_sprite_renderer_if.sv
// Pixel-stream bundle between the VGA scan controller and the tank sprite renderer.
// The master drives scan coordinates and frame timing; the slave returns the resolved pixel.
interface tank_sprite_renderer_if #(
    parameter int COORD_W = 10,
    parameter int IDX_W   = 6
);
    logic               frame_start;
    logic               pix_valid;
    logic [COORD_W-1:0] draw_x;
    logic [COORD_W-1:0] draw_y;
    logic               out_valid;
    logic [IDX_W-1:0]   out_idx;
    logic               out_opaque;
    logic               out_owner;

    modport master (
        output frame_start, pix_valid, draw_x, draw_y,
        input  out_valid, out_idx, out_opaque, out_owner
    );

    modport slave (
        input  frame_start, pix_valid, draw_x, draw_y,
        output out_valid, out_idx, out_opaque, out_owner
    );
endinterface

// File: rtl/tank_sprite_renderer.sv
// Two-stage pixel renderer for the blue and red tank sprites: hit test and row/col in stage 1,
// sprite lookup and priority merge in stage 2, plus a per-frame tank overlap flag.
module tank_sprite_renderer #(
    parameter int SPR_H      = 25,
    parameter int SPR_W      = 18,
    parameter int IDX_W      = 6,
    parameter int COORD_W    = 10,
    parameter bit RED_ON_TOP = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [SPR_H*SPR_W*IDX_W-1:0] blue_tank,
    input  logic [SPR_H*SPR_W*IDX_W-1:0] red_tank,
    input  logic [COORD_W-1:0]           blue_x,
    input  logic [COORD_W-1:0]           blue_y,
    input  logic [COORD_W-1:0]           red_x,
    input  logic [COORD_W-1:0]           red_y,
    input  logic                         blue_dir,
    input  logic                         red_dir,
    tank_sprite_renderer_if.slave        pix,
    output logic                         collision
);
    localparam int NPIX   = SPR_H * SPR_W;
    localparam int ROW_W  = $clog2(SPR_H);
    localparam int COL_W  = $clog2(SPR_W);
    localparam int ELEM_W = $clog2(NPIX);

    // Index 0 is the blue tank, index 1 the red tank throughout.
    logic [COORD_W-1:0] req_x [2];
    logic [COORD_W-1:0] req_y [2];
    logic               req_dir [2];
    logic [IDX_W-1:0]   sprite [2][NPIX];
    logic [IDX_W-1:0]   tank_idx [2];
    logic [1:0]         tank_opq;

    assign req_x[0]   = blue_x;
    assign req_x[1]   = red_x;
    assign req_y[0]   = blue_y;
    assign req_y[1]   = red_y;
    assign req_dir[0] = blue_dir;
    assign req_dir[1] = red_dir;

    // Element [0][0] sits at the MSB end of the packed sprite vector.
    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_unpack
            assign sprite[0][gi] = blue_tank[(NPIX-1-gi)*IDX_W +: IDX_W];
            assign sprite[1][gi] = red_tank[(NPIX-1-gi)*IDX_W +: IDX_W];
        end
    endgenerate

    generate
        for (gi = 0; gi < 2; gi++) begin : g_tank
            logic [COORD_W-1:0] act_x_reg;
            logic [COORD_W-1:0] act_y_reg;
            logic               act_dir_reg;
            logic [COORD_W:0]   dx;
            logic [COORD_W:0]   dy;
            logic               hit;
            logic [ROW_W-1:0]   row_next;
            logic               s1_hit_reg;
            logic [ROW_W-1:0]   s1_row_reg;
            logic [COL_W-1:0]   s1_col_reg;
            logic [ELEM_W-1:0]  elem;

            // The extra MSB acts as the borrow, so sprites left/above the screen origin clip.
            assign dx  = {1'b0, pix.draw_x} - {1'b0, act_x_reg};
            assign dy  = {1'b0, pix.draw_y} - {1'b0, act_y_reg};
            assign hit = !dx[COORD_W] && !dy[COORD_W]
                      && (dx < (COORD_W+1)'(SPR_W)) && (dy < (COORD_W+1)'(SPR_H));

            always_comb begin
                row_next = dy[ROW_W-1:0];
                if (act_dir_reg) begin
                    row_next = ROW_W'(SPR_H - 1) - dy[ROW_W-1:0];
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    act_x_reg   <= '0;
                    act_y_reg   <= '0;
                    act_dir_reg <= 1'b0;
                    s1_hit_reg  <= 1'b0;
                    s1_row_reg  <= '0;
                    s1_col_reg  <= '0;
                end else begin
                    if (pix.frame_start) begin
                        act_x_reg   <= req_x[gi];
                        act_y_reg   <= req_y[gi];
                        act_dir_reg <= req_dir[gi];
                    end
                    s1_hit_reg <= hit && pix.pix_valid;
                    s1_row_reg <= hit ? row_next : '0;
                    s1_col_reg <= hit ? dx[COL_W-1:0] : '0;
                end
            end

            assign elem          = ELEM_W'(s1_row_reg) * ELEM_W'(SPR_W) + ELEM_W'(s1_col_reg);
            assign tank_idx[gi]  = s1_hit_reg ? sprite[gi][elem] : '0;
            assign tank_opq[gi]  = |tank_idx[gi];
        end
    endgenerate

    logic       s1_valid_reg;
    logic [1:0] s2_opq_reg;
    logic       acc_reg;
    logic       win_red;
    logic       ovl;

    assign win_red = tank_opq[1] && (!tank_opq[0] || RED_ON_TOP);
    assign ovl     = pix.out_valid && s2_opq_reg[0] && s2_opq_reg[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_reg   <= 1'b0;
            s2_opq_reg     <= '0;
            acc_reg        <= 1'b0;
            collision      <= 1'b0;
            pix.out_valid  <= 1'b0;
            pix.out_idx    <= '0;
            pix.out_opaque <= 1'b0;
            pix.out_owner  <= 1'b0;
        end else begin
            s1_valid_reg  <= pix.pix_valid;
            pix.out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                pix.out_idx    <= win_red ? tank_idx[1] : tank_idx[0];
                pix.out_opaque <= |tank_opq;
                pix.out_owner  <= win_red;
                s2_opq_reg     <= tank_opq;
            end else begin
                pix.out_idx    <= '0;
                pix.out_opaque <= 1'b0;
                pix.out_owner  <= 1'b0;
                s2_opq_reg     <= '0;
            end
            // The pixel on the outputs during frame_start still counts toward the closing frame.
            if (pix.frame_start) begin
                collision <= acc_reg || ovl;
                acc_reg   <= 1'b0;
            end else begin
                acc_reg <= acc_reg || ovl;
            end
        end
    end
endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Bench for tank_sprite_renderer: directed pinned scenarios plus randomized frames,
// checked cycle by cycle against a coordinate-level model of both tanks.
module tb_tank_sprite_renderer;
    localparam int SPR_H   = 25;
    localparam int SPR_W   = 18;
    localparam int IDX_W   = 6;
    localparam int COORD_W = 10;
    localparam int NPIX    = SPR_H * SPR_W;
    localparam bit RED_ON_TOP = 1'b1;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NPIX*IDX_W-1:0]   blue_tank;
    logic [NPIX*IDX_W-1:0]   red_tank;
    logic [COORD_W-1:0]      blue_x, blue_y, red_x, red_y;
    logic                    blue_dir, red_dir;
    logic                    collision;

    tank_sprite_renderer_if #(.COORD_W(COORD_W), .IDX_W(IDX_W)) pix ();

    tank_sprite_renderer #(
        .SPR_H(SPR_H), .SPR_W(SPR_W), .IDX_W(IDX_W), .COORD_W(COORD_W), .RED_ON_TOP(RED_ON_TOP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .blue_tank(blue_tank), .red_tank(red_tank),
        .blue_x(blue_x), .blue_y(blue_y), .red_x(red_x), .red_y(red_y),
        .blue_dir(blue_dir), .red_dir(red_dir),
        .pix(pix), .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int idx;
        bit opq;
        bit owner;
        bit both;
    } px_t;

    int  spr [2][SPR_H][SPR_W];
    int  act_x [2];
    int  act_y [2];
    bit  act_dir [2];
    bit  acc, coll, live;
    px_t cur, p1;
    int  vectors = 0;
    int  miscompares = 0;

    function automatic px_t eval_pixel(input bit v, input int x, input int y);
        px_t r;
        int  idx [2];
        int  row;
        r = '{default: 0};
        if (!v) return r;
        for (int t = 0; t < 2; t++) begin
            idx[t] = 0;
            if (x >= act_x[t] && x < act_x[t] + SPR_W && y >= act_y[t] && y < act_y[t] + SPR_H) begin
                row = y - act_y[t];
                if (act_dir[t]) row = SPR_H - 1 - row;
                idx[t] = spr[t][row][x - act_x[t]];
            end
        end
        r.valid = 1'b1;
        r.both  = (idx[0] != 0) && (idx[1] != 0);
        if (idx[1] != 0 && (idx[0] == 0 || RED_ON_TOP)) begin
            r.idx = idx[1]; r.owner = 1'b1;
        end else begin
            r.idx = idx[0]; r.owner = 1'b0;
        end
        r.opq = (r.idx != 0);
        return r;
    endfunction

    task automatic model_step();
        bit ovl;
        if (!reset_n) begin
            for (int t = 0; t < 2; t++) begin
                act_x[t] = 0; act_y[t] = 0; act_dir[t] = 1'b0;
            end
            acc = 1'b0; coll = 1'b0;
            cur = '{default: 0}; p1 = '{default: 0};
            live = 1'b1;
        end else begin
            ovl = cur.valid && cur.both;
            if (pix.frame_start) begin
                coll = acc | ovl; acc = 1'b0;
            end else begin
                acc = acc | ovl;
            end
            cur = p1;
            p1  = eval_pixel(pix.pix_valid, int'(pix.draw_x), int'(pix.draw_y));
            if (pix.frame_start) begin
                act_x[0] = int'(blue_x); act_y[0] = int'(blue_y); act_dir[0] = blue_dir;
                act_x[1] = int'(red_x);  act_y[1] = int'(red_y);  act_dir[1] = red_dir;
            end
        end
    endtask

    initial begin
        live = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison of the whole output tuple against the model.
    initial begin
        logic [IDX_W+3:0] got, want;
        forever begin
            @(negedge clk);
            if (live) begin
                got  = {pix.out_valid, pix.out_idx, pix.out_opaque, pix.out_owner, collision};
                want = {cur.valid, IDX_W'(cur.idx), cur.opq, cur.owner, coll};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL pixel_out t=%0t got v=%0b idx=%0d opq=%0b own=%0b coll=%0b want v=%0b idx=%0d opq=%0b own=%0b coll=%0b",
                             $time, got[IDX_W+3], got[IDX_W+2:3], got[2], got[1], got[0],
                             want[IDX_W+3], want[IDX_W+2:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input bit v, input int x, input int y, input bit fs);
        @(negedge clk);
        pix.pix_valid   = v;
        pix.draw_x      = COORD_W'(x);
        pix.draw_y      = COORD_W'(y);
        pix.frame_start = fs;
    endtask

    task automatic new_frame();
        drive(1'b0, 0, 0, 1'b1);
        drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic scan(input int x, input int y, input int e_idx, input int e_own, input string name);
        drive(1'b1, x, y, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        @(negedge clk);
        check_lit({name, "_valid"}, int'(pix.out_valid), 1);
        check_lit({name, "_idx"}, int'(pix.out_idx), e_idx);
        check_lit({name, "_owner"}, int'(pix.out_owner), e_own);
        check_lit({name, "_opaque"}, int'(pix.out_opaque), (e_idx != 0) ? 1 : 0);
    endtask

    task automatic place(input int bx, input int by, input bit bd, input int rx, input int ry, input bit rd);
        blue_x = COORD_W'(bx); blue_y = COORD_W'(by); blue_dir = bd;
        red_x  = COORD_W'(rx); red_y  = COORD_W'(ry); red_dir  = rd;
    endtask

    initial begin
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < SPR_H; r++)
                for (int c = 0; c < SPR_W; c++)
                    spr[t][r][c] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 63));
        spr[0][0][0]  = 0;
        spr[0][1][8]  = 1;
        spr[0][23][8] = 0;
        spr[0][4][8]  = 5;
        spr[1][4][8]  = 1;
        for (int e = 0; e < NPIX; e++) begin
            blue_tank[(NPIX-1-e)*IDX_W +: IDX_W] = IDX_W'(spr[0][e / SPR_W][e % SPR_W]);
            red_tank[(NPIX-1-e)*IDX_W +: IDX_W]  = IDX_W'(spr[1][e / SPR_W][e % SPR_W]);
        end
        place(0, 0, 1'b0, 0, 0, 1'b0);
        pix.pix_valid = 1'b0; pix.draw_x = '0; pix.draw_y = '0; pix.frame_start = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_lit("reset_valid", int'(pix.out_valid), 0);
        check_lit("reset_collision", int'(collision), 0);
        reset_n = 1'b1;

        // Blue alone, upright, then flipped.
        place(100, 50, 1'b0, 600, 400, 1'b0);
        new_frame();
        scan(108, 51, 1, 0, "blue_hit");
        scan(100, 50, 0, 0, "blue_transparent");
        scan(118, 50, 0, 0, "col18_miss");
        scan(99, 50, 0, 0, "left_miss");
        place(100, 50, 1'b1, 600, 400, 1'b0);
        new_frame();
        scan(108, 73, 1, 0, "flip_row1");
        scan(108, 51, 0, 0, "flip_row23");

        // Overlap priority and the per-frame collision flag.
        place(200, 200, 1'b0, 200, 200, 1'b0);
        new_frame();
        scan(208, 204, 1, 1, "red_on_top");
        place(200, 200, 1'b0, 400, 400, 1'b0);
        new_frame();
        check_lit("collision_set", int'(collision), 1);
        scan(208, 204, 5, 0, "blue_only");
        new_frame();
        check_lit("collision_clear", int'(collision), 0);

        // Inputs only take effect at frame_start.
        place(100, 50, 1'b0, 600, 400, 1'b0);
        new_frame();
        scan(108, 51, 1, 0, "pre_move");
        blue_x = COORD_W'(300);
        scan(108, 51, 1, 0, "midframe_hold");
        drive(1'b1, 108, 51, 1'b1);
        drive(1'b1, 108, 51, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        check_lit("fs_same_cycle_old", int'(pix.out_idx), 1);
        @(negedge clk);
        check_lit("fs_next_new", int'(pix.out_idx), 0);

        // Reset while streaming with collision set.
        place(200, 200, 1'b0, 200, 200, 1'b0);
        new_frame();
        scan(208, 204, 1, 1, "pre_reset_overlap");
        new_frame();
        check_lit("pre_reset_collision", int'(collision), 1);
        drive(1'b1, 208, 204, 1'b0);
        drive(1'b1, 208, 204, 1'b0);
        reset_n = 1'b0;
        drive(1'b1, 208, 204, 1'b0);
        reset_n = 1'b1;
        check_lit("rst_valid0", int'(pix.out_valid), 0);
        check_lit("rst_collision", int'(collision), 0);
        check_lit("rst_idx", int'(pix.out_idx), 0);
        check_lit("rst_owner", int'(pix.out_owner), 0);
        drive(1'b1, 208, 204, 1'b0);
        check_lit("rst_valid1", int'(pix.out_valid), 0);
        drive(1'b0, 0, 0, 1'b0);
        check_lit("rst_resume_valid", int'(pix.out_valid), 1);
        check_lit("rst_resume_idx", int'(pix.out_idx), 0);

        // Randomized frames, some hugging the far screen edge.
        for (int f = 0; f < 30; f++) begin
            int base_x, base_y;
            base_x = (f % 3 == 2) ? 960 : 0;
            base_y = (f % 3 == 2) ? 940 : 0;
            place(base_x + int'($urandom_range(0, 40)), base_y + int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
                  base_x + int'($urandom_range(0, 40)), base_y + int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
            drive(1'($urandom_range(0, 1)), base_x + int'($urandom_range(0, 63)), base_y + int'($urandom_range(0, 83)), 1'b1);
            for (int c = 0; c < 160; c++) begin
                if ($urandom_range(0, 15) == 0) blue_x = COORD_W'($urandom);
                if ($urandom_range(0, 15) == 0) red_dir = ~red_dir;
                drive($urandom_range(0, 3) != 0, base_x + int'($urandom_range(0, 63)), base_y + int'($urandom_range(0, 83)), 1'b0);
                reset_n = ($urandom_range(0, 399) != 0);
            end
            reset_n = 1'b1;
        end

        drive(1'b0, 0, 0, 1'b1);
        repeat (4) drive(1'b0, 0, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
